// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the single-bus processor sequencer: widths, IR field
// positions, opcodes and time slots.
package proc_pkg;

  localparam int REG_AW = 3;
  localparam int NREG   = 2 ** REG_AW;
  localparam int IR_W   = 3 + 2 * REG_AW;

  localparam int OPC_HI = IR_W - 1;
  localparam int OPC_LO = 2 * REG_AW;
  localparam int X_HI   = 2 * REG_AW - 1;
  localparam int X_LO   = REG_AW;
  localparam int Y_HI   = REG_AW - 1;
  localparam int Y_LO   = 0;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MVNZ = 3'b100
  } opcode_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tslot_e;

endpackage

// File: rtl/proc_ctrl_if.sv
// Handshake and control bundle between the sequencer (master) and the
// datapath / IR source (slave).
interface proc_ctrl_if;
  import proc_pkg::*;

  logic            Run;
  logic [IR_W-1:0] IR;
  logic            Gnz;
  logic            IRin;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic            Gout;
  logic            DINout;
  logic            Ain;
  logic            Gin;
  logic            AddSub;
  logic            Done;
  logic            Illegal;
  logic [1:0]      Tstep;

  modport master (
    input  Run, IR, Gnz,
    output IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done, Illegal, Tstep
  );

  modport slave (
    output Run, IR, Gnz,
    input  IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub, Done, Illegal, Tstep
  );

endinterface

// File: rtl/proc_ctrl_reg_dec.sv
// Binary-to-one-hot register index decoder; all outputs low when disabled.
module reg_dec #(
  parameter int AW = 3
) (
  input  logic [AW-1:0]        idx,
  input  logic                 en,
  output logic [(1<<AW)-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/proc_ctrl.sv
// Instruction sequencer: a 2-bit slot register plus combinational decode of
// slot, IR, Run and Gnz into the datapath load/drive enables.
module proc_ctrl
  import proc_pkg::*;
(
  input  logic         Pclk,
  input  logic         Reset,
  proc_ctrl_if.master  bus
);

  tslot_e             tstep;
  tslot_e             tstep_nxt;
  opcode_e            opcode;
  logic [REG_AW-1:0]  x_idx;
  logic [REG_AW-1:0]  y_idx;
  logic [NREG-1:0]    x_oh;
  logic [NREG-1:0]    y_oh;
  logic               done;
  logic               rin_x;
  logic               rout_x;
  logic               rout_y;

  assign opcode = opcode_e'(bus.IR[OPC_HI:OPC_LO]);
  assign x_idx  = bus.IR[X_HI:X_LO];
  assign y_idx  = bus.IR[Y_HI:Y_LO];

  reg_dec #(.AW(REG_AW)) u_xdec (.idx(x_idx), .en(rin_x | rout_x), .onehot(x_oh));
  reg_dec #(.AW(REG_AW)) u_ydec (.idx(y_idx), .en(rout_y),         .onehot(y_oh));

  always_ff @(posedge Pclk) begin
    if (Reset) tstep <= T0;
    else       tstep <= tstep_nxt;
  end

  // The slot that raises Done always closes the instruction; T0 waits for Run.
  always_comb begin
    tstep_nxt = tstep;
    if (done)              tstep_nxt = T0;
    else if (tstep == T0)  tstep_nxt = bus.Run ? T1 : T0;
    else                   tstep_nxt = tslot_e'(tstep + 2'd1);
  end

  always_comb begin
    bus.IRin    = 1'b0;
    bus.Gout    = 1'b0;
    bus.DINout  = 1'b0;
    bus.Ain     = 1'b0;
    bus.Gin     = 1'b0;
    bus.AddSub  = 1'b0;
    bus.Illegal = 1'b0;
    done        = 1'b0;
    rin_x       = 1'b0;
    rout_x      = 1'b0;
    rout_y      = 1'b0;
    if (!Reset) begin
      unique case (tstep)
        T0: bus.IRin = bus.Run;
        T1: begin
          unique case (opcode)
            OP_MV:   begin rout_y = 1'b1; rin_x = 1'b1; done = 1'b1; end
            OP_MVI:  begin bus.DINout = 1'b1; rin_x = 1'b1; done = 1'b1; end
            OP_ADD,
            OP_SUB:  begin rout_x = 1'b1; bus.Ain = 1'b1; end
            OP_MVNZ: begin rout_y = bus.Gnz; rin_x = bus.Gnz; done = 1'b1; end
            default: begin bus.Illegal = 1'b1; done = 1'b1; end
          endcase
        end
        // T2/T3 are only reachable by add/sub, since IR is held until Done.
        T2: begin
          rout_y     = 1'b1;
          bus.Gin    = 1'b1;
          bus.AddSub = (opcode == OP_SUB);
        end
        T3: begin
          bus.Gout = 1'b1;
          rin_x    = 1'b1;
          done     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.Rin   = rin_x ? x_oh : '0;
  assign bus.Rout  = rout_x ? x_oh : (rout_y ? y_oh : '0);
  assign bus.Done  = done;
  assign bus.Tstep = tstep;

endmodule

// File: tb/tb_proc_ctrl.sv
// Self-checking bench for proc_ctrl: directed steps then random traffic, checked
// against a per-instruction slot schedule built from the instruction semantics.
module tb_proc_ctrl;
  import proc_pkg::*;

  typedef struct {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       gout;
    logic       dinout;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
    logic       illegal;
    logic [1:0] tstep;
    bit         cond;
  } exp_t;

  logic Pclk = 1'b0;
  logic Reset;
  int   testsRun  = 0;
  int   failCount = 0;
  exp_t schedQ[$];

  proc_ctrl_if bus ();

  proc_ctrl dut (
    .Pclk  (Pclk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Pclk = ~Pclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [7:0] oneHot(input logic [2:0] i);
    logic [7:0] one;
    one = 8'd1;
    return one << i;
  endfunction

  function automatic exp_t slot(input logic [1:0] t, input logic [7:0] rin, input logic [7:0] rout,
                                input logic gout, input logic dinout, input logic ain, input logic gin,
                                input logic addsub, input logic done, input logic illegal, input bit cond);
    exp_t e;
    e.irin = 1'b0; e.rin = rin; e.rout = rout; e.gout = gout; e.dinout = dinout;
    e.ain = ain; e.gin = gin; e.addsub = addsub; e.done = done; e.illegal = illegal;
    e.tstep = t; e.cond = cond;
    return e;
  endfunction

  // Whole micro-op sequence of one instruction, queued when Run is accepted.
  task automatic buildSchedule(input logic [8:0] ir);
    logic [2:0] op;
    logic [7:0] xo;
    logic [7:0] yo;
    op = ir[8:6];
    xo = oneHot(ir[5:3]);
    yo = oneHot(ir[2:0]);
    case (op)
      3'b000: schedQ.push_back(slot(2'd1, xo, yo, 0, 0, 0, 0, 0, 1, 0, 0));
      3'b001: schedQ.push_back(slot(2'd1, xo, 8'h00, 0, 1, 0, 0, 0, 1, 0, 0));
      3'b010, 3'b011: begin
        schedQ.push_back(slot(2'd1, 8'h00, xo, 0, 0, 1, 0, 0, 0, 0, 0));
        schedQ.push_back(slot(2'd2, 8'h00, yo, 0, 0, 0, 1, (op == 3'b011), 0, 0, 0));
        schedQ.push_back(slot(2'd3, xo, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0));
      end
      3'b100: schedQ.push_back(slot(2'd1, xo, yo, 0, 0, 0, 0, 0, 1, 0, 1));
      default: schedQ.push_back(slot(2'd1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1, 0));
    endcase
  endtask

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    int drivers;
    checkOne("IRin",    32'(bus.IRin),    32'(e.irin));
    checkOne("Rin",     32'(bus.Rin),     32'(e.rin));
    checkOne("Rout",    32'(bus.Rout),    32'(e.rout));
    checkOne("Gout",    32'(bus.Gout),    32'(e.gout));
    checkOne("DINout",  32'(bus.DINout),  32'(e.dinout));
    checkOne("Ain",     32'(bus.Ain),     32'(e.ain));
    checkOne("Gin",     32'(bus.Gin),     32'(e.gin));
    checkOne("AddSub",  32'(bus.AddSub),  32'(e.addsub));
    checkOne("Done",    32'(bus.Done),    32'(e.done));
    checkOne("Illegal", 32'(bus.Illegal), 32'(e.illegal));
    checkOne("Tstep",   32'(bus.Tstep),   32'(e.tstep));
    drivers = $countones(bus.Rout) + int'(bus.Gout) + int'(bus.DINout);
    checkOne("busExcl", 32'(drivers <= 1), 32'd1);
    checkOne("rinOneHot", 32'($countones(bus.Rin) <= 1), 32'd1);
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic applyStimulus(input logic rst, input logic run, input logic [8:0] ir, input logic gnz);
    exp_t e;
    Reset   = rst;
    bus.Run = run;
    bus.IR  = ir;
    bus.Gnz = gnz;
    e = slot(2'd0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    if (schedQ.size() > 0) e.tstep = schedQ[0].tstep;
    if (!rst) begin
      if (schedQ.size() == 0) begin
        e.irin = run;
      end else begin
        e = schedQ[0];
        if (e.cond && !gnz) begin
          e.rin  = 8'h00;
          e.rout = 8'h00;
        end
      end
    end
    @(negedge Pclk);
    checkOutput(e);
    if (rst) schedQ.delete();
    else if (schedQ.size() == 0) begin
      if (run) buildSchedule(ir);
    end else void'(schedQ.pop_front());
    @(posedge Pclk);
    #1;
  endtask

  initial begin
    logic [8:0] ir;
    logic       run;
    logic       rst;
    localparam logic [8:0] MV35   = 9'b000_011_101;
    localparam logic [8:0] ADD12  = 9'b010_001_010;
    localparam logic [8:0] SUB12  = 9'b011_001_010;
    localparam logic [8:0] MVNZ07 = 9'b100_000_111;
    localparam logic [8:0] ILL    = 9'b111_000_000;
    localparam logic [8:0] MVI6   = 9'b001_110_000;

    Reset = 1'b1; bus.Run = 1'b0; bus.IR = '0; bus.Gnz = 1'b0;
    @(posedge Pclk); #1;

    applyStimulus(1, 0, 9'd0, 0);
    applyStimulus(1, 0, 9'd0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 9'd0, 0);

    applyStimulus(0, 1, MV35, 0);
    applyStimulus(0, 0, MV35, 0);
    applyStimulus(0, 0, MV35, 0);

    applyStimulus(0, 1, ADD12, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, ADD12, 0);
    applyStimulus(0, 1, SUB12, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, SUB12, 0);

    applyStimulus(0, 1, MVNZ07, 0);
    applyStimulus(0, 0, MVNZ07, 0);
    applyStimulus(0, 1, MVNZ07, 1);
    applyStimulus(0, 0, MVNZ07, 1);

    applyStimulus(0, 1, ADD12, 0);
    applyStimulus(0, 0, ADD12, 0);
    applyStimulus(1, 0, ADD12, 0);
    applyStimulus(0, 0, ADD12, 0);
    applyStimulus(0, 1, MV35, 0);
    applyStimulus(0, 0, MV35, 0);

    applyStimulus(0, 1, ILL, 0);
    applyStimulus(0, 1, ILL, 0);
    applyStimulus(0, 1, MVI6, 0);
    applyStimulus(0, 1, MVI6, 0);
    applyStimulus(0, 0, MVI6, 0);

    ir = 9'd0;
    for (int i = 0; i < 400; i++) begin
      if (schedQ.size() == 0) ir = 9'($urandom_range(0, 511));
      run = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 24) == 0);
      applyStimulus(rst, run, ir, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
